// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I definitions for the pipeline slice.
//   - opcode constants (OP_*)
//   - ALU operation class encodings (ULA_*)
//   - ctrl_t: packed decoder control bundle carried from ID into EX
//   - uses_rs1/uses_rs2: whether an opcode actually reads rs1/rs2
package rv32i_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] ULA_ADD   = 2'b00;
    localparam logic [1:0] ULA_FUNCT = 2'b10;

    typedef struct packed {
        logic       mem_rd;
        logic       mem_wr;
        logic       reg_wr;
        logic       mux_reg_wr;
        logic       mux_ula;
        logic       pc_ula;
        logic       jump;
        logic       branch;
        logic [1:0] ula_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    function automatic logic uses_rs1(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) ||
               (op == OP_STORE) || (op == OP_BRANCH) || (op == OP_JALR);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == OP_R) || (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use hazard detection.
//   in : opcode_id, rs1_id, rs2_id (instruction in ID)
//        rd_ex, mem_rd_ex, valid_ex (instruction in EX)
//        hold_in (downstream stall)
//   out: load_use (ID depends on a load currently in EX)
//        stall_id (hold PC and IF/ID this cycle)
module hazard_detect
    import rv32i_pkg::*;
(
    input  logic [6:0] opcode_id,
    input  logic [4:0] rs1_id,
    input  logic [4:0] rs2_id,
    input  logic [4:0] rd_ex,
    input  logic       mem_rd_ex,
    input  logic       valid_ex,
    input  logic       hold_in,
    output logic       load_use,
    output logic       stall_id
);

    always_comb begin
        load_use = 1'b0;
        // Only operand fields the opcode really reads count; a load to x0
        // never produces data anyone waits for.
        if (valid_ex && mem_rd_ex && (rd_ex != 5'd0)) begin
            load_use = (uses_rs1(opcode_id) && (rs1_id == rd_ex)) ||
                       (uses_rs2(opcode_id) && (rs2_id == rd_ex));
        end
        stall_id = load_use | hold_in;
    end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble insertion,
// flush handling and saturating debug counters.
//   in : clk, rst_n (async, active low)
//        opcode_id, decoder control bundle, operands, indices, funct fields
//        hold_in (freeze stage), flush_ex (kill instruction in ID)
//   out: *_ex registered copies of the ID inputs (except opcode)
//        valid_ex, stall_id, stall_cnt, flush_cnt
module id_ex_stage
    import rv32i_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [6:0]      opcode_id,
    input  logic            mem_rd_id,
    input  logic            mem_wr_id,
    input  logic            reg_wr_id,
    input  logic            mux_reg_wr_id,
    input  logic            mux_ula_id,
    input  logic            pc_ula_id,
    input  logic            jump_id,
    input  logic            branch_id,
    input  logic [1:0]      ula_op_id,
    input  logic [XLEN-1:0] pc_id,
    input  logic [XLEN-1:0] rs1_val_id,
    input  logic [XLEN-1:0] rs2_val_id,
    input  logic [XLEN-1:0] imm_id,
    input  logic [4:0]      rs1_id,
    input  logic [4:0]      rs2_id,
    input  logic [4:0]      rd_id,
    input  logic [2:0]      funct3_id,
    input  logic            funct7b5_id,
    input  logic            hold_in,
    input  logic            flush_ex,
    output logic            mem_rd_ex,
    output logic            mem_wr_ex,
    output logic            reg_wr_ex,
    output logic            mux_reg_wr_ex,
    output logic            mux_ula_ex,
    output logic            pc_ula_ex,
    output logic            jump_ex,
    output logic            branch_ex,
    output logic [1:0]      ula_op_ex,
    output logic [XLEN-1:0] pc_ex,
    output logic [XLEN-1:0] rs1_val_ex,
    output logic [XLEN-1:0] rs2_val_ex,
    output logic [XLEN-1:0] imm_ex,
    output logic [4:0]      rs1_ex,
    output logic [4:0]      rs2_ex,
    output logic [4:0]      rd_ex,
    output logic [2:0]      funct3_ex,
    output logic            funct7b5_ex,
    output logic            valid_ex,
    output logic            stall_id,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    ctrl_t ctrl_id;
    ctrl_t ctrl_q;
    logic  load_use;
    logic  update;
    logic  bubble;

    hazard_detect u_hazard (
        .opcode_id (opcode_id),
        .rs1_id    (rs1_id),
        .rs2_id    (rs2_id),
        .rd_ex     (rd_ex),
        .mem_rd_ex (mem_rd_ex),
        .valid_ex  (valid_ex),
        .hold_in   (hold_in),
        .load_use  (load_use),
        .stall_id  (stall_id)
    );

    // Branches never write back and x0 is hardwired, so reg_wr is cleaned here.
    always_comb begin
        ctrl_id            = CTRL_NOP;
        ctrl_id.mem_rd     = mem_rd_id;
        ctrl_id.mem_wr     = mem_wr_id;
        ctrl_id.reg_wr     = reg_wr_id & ~branch_id & (rd_id != 5'd0);
        ctrl_id.mux_reg_wr = mux_reg_wr_id;
        ctrl_id.mux_ula    = mux_ula_id;
        ctrl_id.pc_ula     = pc_ula_id;
        ctrl_id.jump       = jump_id;
        ctrl_id.branch     = branch_id;
        ctrl_id.ula_op     = ula_op_id;
    end

    // Flush beats hold, hold beats load-use: the register loads unless held
    // without a flush, and what it loads is a bubble on flush or load-use.
    assign update = flush_ex | ~hold_in;
    assign bubble = flush_ex | load_use;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q      <= CTRL_NOP;
            valid_ex    <= 1'b0;
            pc_ex       <= '0;
            rs1_val_ex  <= '0;
            rs2_val_ex  <= '0;
            imm_ex      <= '0;
            rs1_ex      <= '0;
            rs2_ex      <= '0;
            rd_ex       <= '0;
            funct3_ex   <= '0;
            funct7b5_ex <= 1'b0;
        end else if (update) begin
            ctrl_q      <= bubble ? CTRL_NOP : ctrl_id;
            valid_ex    <= ~bubble;
            pc_ex       <= pc_id;
            rs1_val_ex  <= rs1_val_id;
            rs2_val_ex  <= rs2_val_id;
            imm_ex      <= imm_id;
            rs1_ex      <= rs1_id;
            rs2_ex      <= rs2_id;
            rd_ex       <= rd_id;
            funct3_ex   <= funct3_id;
            funct7b5_ex <= funct7b5_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (load_use && !flush_ex && !hold_in && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (flush_ex && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign mem_rd_ex     = ctrl_q.mem_rd;
    assign mem_wr_ex     = ctrl_q.mem_wr;
    assign reg_wr_ex     = ctrl_q.reg_wr;
    assign mux_reg_wr_ex = ctrl_q.mux_reg_wr;
    assign mux_ula_ex    = ctrl_q.mux_ula;
    assign pc_ula_ex     = ctrl_q.pc_ula;
    assign jump_ex       = ctrl_q.jump;
    assign branch_ex     = ctrl_q.branch;
    assign ula_op_ex     = ctrl_q.ula_op;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed scenarios plus randomized traffic, all checked
// against a behavioural model of the ID/EX stage kept in this bench.
// A second instance with 2-bit counters exercises saturation.
module tb_id_ex_stage;

    localparam logic [6:0] OPS [9] = '{7'b0110011, 7'b0010011, 7'b0000011,
                                       7'b0100011, 7'b1100011, 7'b0110111,
                                       7'b0010111, 7'b1101111, 7'b1100111};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [6:0]  opcode_id;
    logic        mem_rd_id, mem_wr_id, reg_wr_id, mux_reg_wr_id;
    logic        mux_ula_id, pc_ula_id, jump_id, branch_id;
    logic [1:0]  ula_op_id;
    logic [31:0] pc_id, rs1_val_id, rs2_val_id, imm_id;
    logic [4:0]  rs1_id, rs2_id, rd_id;
    logic [2:0]  funct3_id;
    logic        funct7b5_id, hold_in, flush_ex;

    logic        mem_rd_ex, mem_wr_ex, reg_wr_ex, mux_reg_wr_ex;
    logic        mux_ula_ex, pc_ula_ex, jump_ex, branch_ex;
    logic [1:0]  ula_op_ex;
    logic [31:0] pc_ex, rs1_val_ex, rs2_val_ex, imm_ex;
    logic [4:0]  rs1_ex, rs2_ex, rd_ex;
    logic [2:0]  funct3_ex;
    logic        funct7b5_ex, valid_ex, stall_id;
    logic [15:0] stall_cnt, flush_cnt;

    // Outputs of the small-counter instance; only its counters are checked.
    logic        s_mem_rd, s_mem_wr, s_reg_wr, s_mux_reg_wr, s_mux_ula;
    logic        s_pc_ula, s_jump, s_branch, s_f7, s_valid, s_stall;
    logic [1:0]  s_ula_op;
    logic [31:0] s_pc, s_rs1v, s_rs2v, s_imm;
    logic [4:0]  s_rs1, s_rs2, s_rd;
    logic [2:0]  s_f3;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    id_ex_stage #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .opcode_id(opcode_id),
        .mem_rd_id(mem_rd_id), .mem_wr_id(mem_wr_id), .reg_wr_id(reg_wr_id),
        .mux_reg_wr_id(mux_reg_wr_id), .mux_ula_id(mux_ula_id), .pc_ula_id(pc_ula_id),
        .jump_id(jump_id), .branch_id(branch_id), .ula_op_id(ula_op_id),
        .pc_id(pc_id), .rs1_val_id(rs1_val_id), .rs2_val_id(rs2_val_id), .imm_id(imm_id),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id), .funct3_id(funct3_id),
        .funct7b5_id(funct7b5_id), .hold_in(hold_in), .flush_ex(flush_ex),
        .mem_rd_ex(mem_rd_ex), .mem_wr_ex(mem_wr_ex), .reg_wr_ex(reg_wr_ex),
        .mux_reg_wr_ex(mux_reg_wr_ex), .mux_ula_ex(mux_ula_ex), .pc_ula_ex(pc_ula_ex),
        .jump_ex(jump_ex), .branch_ex(branch_ex), .ula_op_ex(ula_op_ex),
        .pc_ex(pc_ex), .rs1_val_ex(rs1_val_ex), .rs2_val_ex(rs2_val_ex), .imm_ex(imm_ex),
        .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex), .funct3_ex(funct3_ex),
        .funct7b5_ex(funct7b5_ex), .valid_ex(valid_ex), .stall_id(stall_id),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    id_ex_stage #(.XLEN(32), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .opcode_id(opcode_id),
        .mem_rd_id(mem_rd_id), .mem_wr_id(mem_wr_id), .reg_wr_id(reg_wr_id),
        .mux_reg_wr_id(mux_reg_wr_id), .mux_ula_id(mux_ula_id), .pc_ula_id(pc_ula_id),
        .jump_id(jump_id), .branch_id(branch_id), .ula_op_id(ula_op_id),
        .pc_id(pc_id), .rs1_val_id(rs1_val_id), .rs2_val_id(rs2_val_id), .imm_id(imm_id),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id), .funct3_id(funct3_id),
        .funct7b5_id(funct7b5_id), .hold_in(hold_in), .flush_ex(flush_ex),
        .mem_rd_ex(s_mem_rd), .mem_wr_ex(s_mem_wr), .reg_wr_ex(s_reg_wr),
        .mux_reg_wr_ex(s_mux_reg_wr), .mux_ula_ex(s_mux_ula), .pc_ula_ex(s_pc_ula),
        .jump_ex(s_jump), .branch_ex(s_branch), .ula_op_ex(s_ula_op),
        .pc_ex(s_pc), .rs1_val_ex(s_rs1v), .rs2_val_ex(s_rs2v), .imm_ex(s_imm),
        .rs1_ex(s_rs1), .rs2_ex(s_rs2), .rd_ex(s_rd), .funct3_ex(s_f3),
        .funct7b5_ex(s_f7), .valid_ex(s_valid), .stall_id(s_stall),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    int total = 0;
    int bad = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_ctrl order: mem_rd, mem_wr, reg_wr, mux_reg_wr, mux_ula, pc_ula, jump, branch, ula_op[1:0]
    logic        m_valid;
    logic [9:0]  m_ctrl;
    logic [31:0] m_pc, m_rs1v, m_rs2v, m_imm;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [2:0]  m_f3;
    logic        m_f7;
    int          m_sc, m_fc;

    function automatic bit reads_rs1(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1100111};
    endfunction

    function automatic bit reads_rs2(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0100011, 7'b1100011};
    endfunction

    function automatic bit model_lu();
        if (!m_valid || !m_ctrl[9] || m_rd == 5'd0) return 1'b0;
        return (reads_rs1(opcode_id) && rs1_id == m_rd) ||
               (reads_rs2(opcode_id) && rs2_id == m_rd);
    endfunction

    function automatic int sat(input int c, input int mx);
        return (c > mx) ? mx : c;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_ctrl = '0; m_pc = '0; m_rs1v = '0; m_rs2v = '0; m_imm = '0;
        m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_f3 = '0; m_f7 = 0; m_sc = 0; m_fc = 0;
    endtask

    task automatic model_load(input bit kill);
        m_pc = pc_id; m_rs1v = rs1_val_id; m_rs2v = rs2_val_id; m_imm = imm_id;
        m_rs1 = rs1_id; m_rs2 = rs2_id; m_rd = rd_id; m_f3 = funct3_id; m_f7 = funct7b5_id;
        m_valid = !kill;
        if (kill) m_ctrl = '0;
        else m_ctrl = {mem_rd_id, mem_wr_id, reg_wr_id && !branch_id && rd_id != 0,
                       mux_reg_wr_id, mux_ula_id, pc_ula_id, jump_id, branch_id, ula_op_id};
    endtask

    task automatic model_edge();
        bit lu = model_lu();
        if (flush_ex) begin
            m_fc++;
            model_load(1);
        end else if (hold_in) begin
            // contents frozen
        end else if (lu) begin
            m_sc++;
            model_load(1);
        end else begin
            model_load(0);
        end
    endtask

    task automatic check_outputs();
        check_val("valid_ex", valid_ex, m_valid);
        check_val("ctrl_ex", {mem_rd_ex, mem_wr_ex, reg_wr_ex, mux_reg_wr_ex, mux_ula_ex,
                              pc_ula_ex, jump_ex, branch_ex, ula_op_ex}, m_ctrl);
        check_val("pc_ex", pc_ex, m_pc);
        check_val("rs_vals_ex", {rs1_val_ex, rs2_val_ex}, {m_rs1v, m_rs2v});
        check_val("imm_ex", imm_ex, m_imm);
        check_val("idx_ex", {rs1_ex, rs2_ex, rd_ex, funct3_ex, funct7b5_ex},
                  {m_rs1, m_rs2, m_rd, m_f3, m_f7});
        check_val("stall_cnt", stall_cnt, sat(m_sc, 65535));
        check_val("flush_cnt", flush_cnt, sat(m_fc, 65535));
        check_val("sat_cnts", {s_stall_cnt, s_flush_cnt}, {2'(sat(m_sc, 3)), 2'(sat(m_fc, 3))});
    endtask

    // Inputs are set shortly after a rising edge; stall_id is checked on the
    // falling edge, the model advances, and registers are checked after the edge.
    task automatic tick();
        @(negedge clk);
        check_val("stall_id", stall_id, model_lu() || hold_in);
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic set_ins(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                           input logic [4:0] rd, input bit mrd, input bit rwr, input bit br);
        opcode_id = op; rs1_id = r1; rs2_id = r2; rd_id = rd;
        mem_rd_id = mrd; reg_wr_id = rwr; branch_id = br;
        mem_wr_id = (op == 7'b0100011); mux_reg_wr_id = mrd; mux_ula_id = (op != 7'b0110011);
        pc_ula_id = 0; jump_id = 0; ula_op_id = (op == 7'b0110011) ? 2'b10 : 2'b00;
        pc_id = $urandom; rs1_val_id = $urandom; rs2_val_id = $urandom; imm_id = $urandom;
        funct3_id = 3'($urandom); funct7b5_id = 1'($urandom);
        hold_in = 0; flush_ex = 0;
    endtask

    task automatic load_use_pair();
        set_ins(7'b0000011, 5'd1, 5'd0, 5'd5, 1, 1, 0);  // lw x5,0(x1)
        tick();
        set_ins(7'b0110011, 5'd5, 5'd2, 5'd6, 0, 1, 0);  // add x6,x5,x2
        tick();
        tick();
    endtask

    int f0, s0;

    initial begin
        model_reset();
        set_ins(7'b0010011, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1;

        // load-use: one stall cycle, one bubble, then the add enters EX
        set_ins(7'b0000011, 5'd1, 5'd0, 5'd5, 1, 1, 0);
        tick();
        set_ins(7'b0110011, 5'd5, 5'd2, 5'd6, 0, 1, 0);
        #1 check_val("lu_stall_id", stall_id, 1);
        tick();
        check_val("lu_bubble", {valid_ex, reg_wr_ex}, 2'b00);
        #1 check_val("lu_stall_released", stall_id, 0);
        tick();
        check_val("lu_add_in_ex", {valid_ex, rs1_ex}, {1'b1, 5'd5});
        check_val("lu_stall_cnt", stall_cnt, 1);

        // asynchronous reset with valid_ex=1 and stall_cnt=5
        repeat (4) load_use_pair();
        check_val("pre_reset", {valid_ex, stall_cnt}, {1'b1, 16'd5});
        rst_n = 0;
        #1;
        model_reset();
        check_val("reset_async", {valid_ex, reg_wr_ex, mem_rd_ex, pc_ex, stall_cnt, flush_cnt},
                  '0);
        check_val("reset_stall_id", stall_id, hold_in);
        check_outputs();
        #1 rst_n = 1;

        // no false hazards
        set_ins(7'b0000011, 5'd1, 5'd0, 5'd0, 1, 1, 0);  // lw x0
        tick();
        set_ins(7'b0110011, 5'd0, 5'd2, 5'd6, 0, 1, 0);  // add x6,x0,x2
        #1 check_val("ld_x0_nostall", stall_id, 0);
        tick();
        set_ins(7'b0000011, 5'd1, 5'd0, 5'd5, 1, 1, 0);
        tick();
        set_ins(7'b0110111, 5'd5, 5'd5, 5'd5, 0, 1, 0);  // lui x5
        #1 check_val("lui_nostall", stall_id, 0);
        tick();
        set_ins(7'b0000011, 5'd1, 5'd0, 5'd5, 1, 1, 0);
        tick();
        set_ins(7'b0010011, 5'd7, 5'd5, 5'd6, 0, 1, 0);  // addi x6,x7,5
        #1 check_val("addi_rs2_nostall", stall_id, 0);
        tick();

        // flush beats hold and load-use
        set_ins(7'b0000011, 5'd1, 5'd0, 5'd5, 1, 1, 0);
        tick();
        f0 = m_fc; s0 = m_sc;
        set_ins(7'b0110011, 5'd5, 5'd2, 5'd6, 0, 1, 0);
        hold_in = 1; flush_ex = 1;
        tick();
        check_val("flush_bubble", valid_ex, 0);
        check_val("flush_counts", {flush_cnt, stall_cnt}, {16'(f0 + 1), 16'(s0)});

        // hold freezes EX for three edges
        set_ins(7'b0010011, 5'd3, 5'd0, 5'd4, 0, 1, 0);
        pc_id = 32'h100;
        tick();
        pc_id = 32'h200; hold_in = 1;
        for (int i = 0; i < 3; i++) begin
            #1 check_val("hold_stall_id", stall_id, 1);
            tick();
            check_val("hold_pc_ex", pc_ex, 32'h100);
        end
        hold_in = 0;

        // write-enable sanitising
        set_ins(7'b1100011, 5'd1, 5'd2, 5'd5, 0, 1, 1);
        tick();
        check_val("btype_no_wr", {valid_ex, reg_wr_ex}, 2'b10);
        set_ins(7'b0010011, 5'd1, 5'd0, 5'd0, 0, 1, 0);
        tick();
        check_val("x0_no_wr", {valid_ex, reg_wr_ex}, 2'b10);
        set_ins(7'b0010011, 5'd1, 5'd0, 5'd6, 0, 1, 0);
        tick();
        check_val("addi_wr", reg_wr_ex, 1);

        // counter saturation on the 2-bit instance
        for (int i = 0; i < 4; i++) begin
            set_ins(7'b0010011, 5'd1, 5'd0, 5'd6, 0, 1, 0);
            flush_ex = 1;
            tick();
        end
        check_val("flush_sat", s_flush_cnt, 2'b11);

        // randomized traffic with small register indices to provoke hazards
        for (int i = 0; i < 400; i++) begin
            set_ins(OPS[$urandom_range(0, 8)], 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    ($urandom_range(0, 9) < 4), 1'($urandom), ($urandom_range(0, 9) < 2));
            mem_wr_id = 1'($urandom); mux_reg_wr_id = 1'($urandom); mux_ula_id = 1'($urandom);
            pc_ula_id = 1'($urandom); jump_id = 1'($urandom); ula_op_id = 2'($urandom);
            hold_in = ($urandom_range(0, 99) < 15);
            flush_ex = ($urandom_range(0, 99) < 10);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
